// File: rtl/bilinear_interp_core.sv
// Bilinear / nearest-neighbour interpolation of a 2x2 sample window with a
// run-time fractional phase. Three register stages (weights, products, sum)
// with a valid/ready handshake on both sides; every stage advances together.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   mode                   0 = bilinear, 1 = nearest (sampled with each beat)
//   in_valid / in_ready    input handshake (in_ready is combinational)
//   fx, fy                 horizontal / vertical phase, f/2^FRAC_W
//   p00, p10, p01, p11     TL, TR, BL, BR samples, CH channels of DW bits
//   in_user                sideband carried unmodified with the beat
//   out_valid / out_ready  output handshake
//   out_pix, out_user      interpolated pixel and its sideband
module bilinear_interp_core #(
  parameter int unsigned DW     = 8,
  parameter int unsigned CH     = 1,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned USER_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FRAC_W-1:0]    fx,
  input  logic [FRAC_W-1:0]    fy,
  input  logic [CH*DW-1:0]     p00,
  input  logic [CH*DW-1:0]     p10,
  input  logic [CH*DW-1:0]     p01,
  input  logic [CH*DW-1:0]     p11,
  input  logic [USER_W-1:0]    in_user,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DW-1:0]     out_pix,
  output logic [USER_W-1:0]    out_user
);

  localparam int unsigned PXW = CH * DW;
  localparam int unsigned WW  = 2 * FRAC_W + 1;   // weight width, max 2^(2F)
  localparam int unsigned PW  = DW + WW;          // product width
  localparam int unsigned SW  = PW + 2;           // sum of four products
  localparam int unsigned RW  = SW - 2 * FRAC_W;  // sum after the 2F shift

  // Whole pipeline moves only when the output slot is free or being drained.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: weights. Index order 0..3 = w00, w10, w01, w11.
  logic [FRAC_W:0]         ax, ay;
  logic [3:0][WW-1:0]      w_d, w_q;
  logic [3:0][PXW-1:0]     smp_q;
  logic [USER_W-1:0]       user1_q;
  logic                    v1_q;

  always_comb begin
    ax  = (FRAC_W+1)'(1 << FRAC_W) - {1'b0, fx};
    ay  = (FRAC_W+1)'(1 << FRAC_W) - {1'b0, fy};
    w_d = '0;
    if (mode) begin
      // Nearest: the phase MSB picks the closer column/row; full weight there.
      w_d[{fy[FRAC_W-1], fx[FRAC_W-1]}] = WW'(1) << (2 * FRAC_W);
    end else begin
      w_d[0] = WW'(ax) * WW'(ay);
      w_d[1] = WW'(fx) * WW'(ay);
      w_d[2] = WW'(ax) * WW'(fy);
      w_d[3] = WW'(fx) * WW'(fy);
    end
  end

  // Stage 2: per-channel products sample * weight.
  logic [CH-1:0][3:0][PW-1:0] prod_d, prod_q;
  logic [USER_W-1:0]          user2_q;
  logic                       v2_q;

  always_comb begin
    prod_d = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        prod_d[c][k] = PW'(smp_q[k][c*DW +: DW]) * PW'(w_q[k]);
      end
    end
  end

  // Stage 3: accumulate, round half up, drop the 2F fraction bits, clamp.
  logic [SW-1:0]     acc;
  logic [RW-1:0]     rnd;
  logic [PXW-1:0]    pix_d, pix3_q;
  logic [USER_W-1:0] user3_q;
  logic              v3_q;

  always_comb begin
    acc   = '0;
    rnd   = '0;
    pix_d = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      acc = SW'(prod_q[c][0]) + SW'(prod_q[c][1]) + SW'(prod_q[c][2]) +
            SW'(prod_q[c][3]) + (SW'(1) << (2 * FRAC_W - 1));
      rnd = acc[SW-1:2*FRAC_W];
      if (|rnd[RW-1:DW]) pix_d[c*DW +: DW] = '1;
      else               pix_d[c*DW +: DW] = rnd[DW-1:0];
    end
  end

  // Pipeline registers; all hold when the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      w_q     <= '0;
      smp_q   <= '0;
      user1_q <= '0;
      v2_q    <= 1'b0;
      prod_q  <= '0;
      user2_q <= '0;
      v3_q    <= 1'b0;
      pix3_q  <= '0;
      user3_q <= '0;
    end else if (adv) begin
      v1_q    <= in_valid;
      w_q     <= w_d;
      smp_q   <= {p11, p01, p10, p00};
      user1_q <= in_user;
      v2_q    <= v1_q;
      prod_q  <= prod_d;
      user2_q <= user1_q;
      v3_q    <= v2_q;
      pix3_q  <= pix_d;
      user3_q <= user2_q;
    end
  end

  assign out_valid = v3_q;
  assign out_pix   = pix3_q;
  assign out_user  = user3_q;

endmodule

// File: tb/tb_bilinear_interp_core.sv
module tb_bilinear_interp_core;

  localparam int unsigned DW  = 8;
  localparam int unsigned CH  = 3;
  localparam int unsigned FW  = 8;
  localparam int unsigned UW  = 2;
  localparam int unsigned PXW = CH * DW;

  typedef struct {
    logic           m;
    logic [FW-1:0]  fx;
    logic [FW-1:0]  fy;
    logic [PXW-1:0] p00;
    logic [PXW-1:0] p10;
    logic [PXW-1:0] p01;
    logic [PXW-1:0] p11;
    logic [UW-1:0]  u;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic           in_valid;
  logic           in_ready;
  logic [FW-1:0]  fx, fy;
  logic [PXW-1:0] p00, p10, p01, p11;
  logic [UW-1:0]  in_user;
  logic           out_valid;
  logic           out_ready;
  logic [PXW-1:0] out_pix;
  logic [UW-1:0]  out_user;

  int errors = 0;
  int checks = 0;

  bilinear_interp_core #(.DW(DW), .CH(CH), .FRAC_W(FW), .USER_W(UW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .fx(fx), .fy(fy), .p00(p00), .p10(p10), .p01(p01), .p11(p11), .in_user(in_user),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_user(out_user)
  );

  always #5 clk = ~clk;

  // Reference: weighted average of the four corners with real-valued weights
  // scaled by 256*256, rounded half up; nearest picks the closer corner.
  function automatic logic [PXW-1:0] model(input beat_t b);
    logic [PXW-1:0] r;
    longint a0, a1, a2, a3, x, y, s;
    r = '0;
    x = longint'(b.fx);
    y = longint'(b.fy);
    for (int c = 0; c < CH; c++) begin
      a0 = longint'(b.p00[c*DW +: DW]);
      a1 = longint'(b.p10[c*DW +: DW]);
      a2 = longint'(b.p01[c*DW +: DW]);
      a3 = longint'(b.p11[c*DW +: DW]);
      if (b.m) begin
        if (y >= 128) s = (x >= 128) ? a3 : a2;
        else          s = (x >= 128) ? a1 : a0;
      end else begin
        s = a0 * (256 - x) * (256 - y) + a1 * x * (256 - y) +
            a2 * (256 - x) * y + a3 * x * y;
        s = (s + 32768) / 65536;
        if (s > 255) s = 255;
      end
      r[c*DW +: DW] = DW'(s);
    end
    return r;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.m   = 1'($urandom % 2);
    b.fx  = FW'($urandom);
    b.fy  = FW'($urandom);
    if ($urandom % 8 == 0) b.fx = '0;
    if ($urandom % 8 == 0) b.fy = '1;
    b.p00 = PXW'($urandom);
    b.p10 = PXW'($urandom);
    b.p01 = PXW'($urandom);
    b.p11 = PXW'($urandom);
    b.u   = UW'($urandom);
    return b;
  endfunction

  function automatic beat_t mk(input logic m, input logic [FW-1:0] x, input logic [FW-1:0] y,
                               input logic [PXW-1:0] a, input logic [PXW-1:0] b2,
                               input logic [PXW-1:0] c, input logic [PXW-1:0] d,
                               input logic [UW-1:0] u);
    beat_t b;
    b.m = m; b.fx = x; b.fy = y; b.p00 = a; b.p10 = b2; b.p01 = c; b.p11 = d; b.u = u;
    return b;
  endfunction

  task automatic apply(input beat_t b);
    mode = b.m; fx = b.fx; fy = b.fy;
    p00 = b.p00; p10 = b.p10; p01 = b.p01; p11 = b.p11; in_user = b.u;
  endtask

  // Send one beat into an idle pipeline; report the result, the number of
  // rising edges from acceptance to out_valid, and out_valid one cycle later.
  task automatic do_single(input beat_t b, output logic [PXW-1:0] pix,
                           output logic [UW-1:0] user, output int lat, output logic v_after);
    @(negedge clk);
    apply(b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    pix  = out_pix;
    user = out_user;
    @(posedge clk);
    @(negedge clk);
    v_after = out_valid;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++;
    if (out_pix !== '0) begin errors++; $display("FAIL reset_pix got=%h want=0", out_pix); end
    checks++;
    if (out_user !== '0) begin errors++; $display("FAIL reset_user got=%h want=0", out_user); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_zero_phase();
    logic [PXW-1:0] pix; logic [UW-1:0] u; int lat; logic va;
    do_single(mk(1'b0, 8'd0, 8'd0, 24'h252525, 24'hC8C8C8, 24'hC8C8C8, 24'hC8C8C8, 2'b10),
              pix, u, lat, va);
    checks++;
    if (pix !== 24'h252525) begin errors++; $display("FAIL zero_phase_pix got=%h want=252525", pix); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL zero_phase_latency got=%0d want=3", lat); end
    checks++;
    if (va !== 1'b0) begin errors++; $display("FAIL zero_phase_one_cycle got=%b want=0", va); end
    checks++;
    if (u !== 2'b10) begin errors++; $display("FAIL zero_phase_user got=%b want=10", u); end
    do_single(mk(1'b1, 8'd0, 8'd0, 24'h0A141E, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 2'b01),
              pix, u, lat, va);
    checks++;
    if (pix !== 24'h0A141E) begin errors++; $display("FAIL nearest_zero_pix got=%h want=0a141e", pix); end
  endtask

  task automatic test_half_phase();
    logic [PXW-1:0] pix; logic [UW-1:0] u; int lat; logic va;
    do_single(mk(1'b0, 8'd128, 8'd128, 24'h000000, 24'h646464, 24'hC8C8C8, 24'hFFFFFF, 2'b00),
              pix, u, lat, va);
    checks++;
    if (pix !== 24'h8B8B8B) begin errors++; $display("FAIL half_bilinear got=%h want=8b8b8b", pix); end
    do_single(mk(1'b1, 8'd128, 8'd128, 24'h000000, 24'h646464, 24'hC8C8C8, 24'hFFFFFF, 2'b11),
              pix, u, lat, va);
    checks++;
    if (pix !== 24'hFFFFFF) begin errors++; $display("FAIL half_nearest got=%h want=ffffff", pix); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL nearest_latency got=%0d want=3", lat); end
  endtask

  task automatic test_edges();
    logic [PXW-1:0] pix; logic [UW-1:0] u; int lat; logic va;
    do_single(mk(1'b0, 8'd85, 8'd0, 24'h000000, 24'hFFFFFF, 24'h123456, 24'h789ABC, 2'b01),
              pix, u, lat, va);
    checks++;
    if (pix !== 24'h555555) begin errors++; $display("FAIL fx85 got=%h want=555555", pix); end
    do_single(mk(1'b0, 8'd255, 8'd255, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 2'b10),
              pix, u, lat, va);
    checks++;
    if (pix !== 24'hFFFFFF) begin errors++; $display("FAIL max_no_overflow got=%h want=ffffff", pix); end
  endtask

  task automatic test_channels();
    logic [PXW-1:0] pix, exp_pix; logic [UW-1:0] u; int lat; logic va;
    beat_t b;
    b = mk(1'b0, 8'd64, 8'd192, 24'h0A80F0, 24'h3C0000, 24'hC814FF, 24'h6432AA, 2'b01);
    exp_pix = model(b);
    do_single(b, pix, u, lat, va);
    checks++;
    if (pix !== exp_pix) begin errors++; $display("FAIL channels got=%h want=%h", pix, exp_pix); end
    for (int i = 0; i < 20; i++) begin
      b = rand_beat();
      exp_pix = model(b);
      do_single(b, pix, u, lat, va);
      checks++;
      if (pix !== exp_pix || u !== b.u) begin
        errors++;
        $display("FAIL random_single[%0d] got=%h/%b want=%h/%b", i, pix, u, exp_pix, b.u);
      end
    end
  endtask

  task automatic test_back_to_back();
    beat_t b[8];
    logic [PXW-1:0] exp_pix;
    for (int i = 0; i < 8; i++) b[i] = rand_beat();
    out_ready = 1'b1;
    for (int j = 0; j <= 11; j++) begin
      @(negedge clk);
      if (j >= 3 && j <= 10) begin
        exp_pix = model(b[j-3]);
        checks++;
        if (out_valid !== 1'b1 || out_pix !== exp_pix || out_user !== b[j-3].u) begin
          errors++;
          $display("FAIL b2b[%0d] got v=%b %h/%b want v=1 %h/%b", j - 3, out_valid, out_pix,
                   out_user, exp_pix, b[j-3].u);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d] got=%b want=0", j, out_valid); end
      end
      if (j < 8) begin apply(b[j]); in_valid = 1'b1; end
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_stream();
    beat_t          exp_q[$];
    beat_t          nb, eb;
    logic [PXW-1:0] exp_pix, hold_pix;
    logic [UW-1:0]  hold_user;
    logic           hold, acc, take;
    int             sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; hold = 1'b0; acc = 1'b0;
    hold_pix = '0; hold_user = '0;
    while (recv < 16 && cyc < 400) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < 16 && ($urandom % 4) != 0) begin
        nb = rand_beat();
        apply(nb);
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom % 2);
      #1;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_pix !== hold_pix || out_user !== hold_user) begin
          errors++;
          $display("FAIL stall_hold got v=%b %h/%b want v=1 %h/%b", out_valid, out_pix, out_user,
                   hold_pix, hold_user);
        end
      end
      hold      = out_valid && !out_ready;
      hold_pix  = out_pix;
      hold_user = out_user;
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (acc) exp_q.push_back(nb);
      if (take) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra got=%h want=none", out_pix);
        end else begin
          eb = exp_q.pop_front();
          exp_pix = model(eb);
          if (out_pix !== exp_pix || out_user !== eb.u) begin
            errors++;
            $display("FAIL stream[%0d] got=%h/%b want=%h/%b", recv, out_pix, out_user, exp_pix, eb.u);
          end
        end
        recv++;
      end
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != 16) begin errors++; $display("FAIL stream_count got=%0d want=16", recv); end
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_drain got v=%b left=%0d want v=0 left=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [PXW-1:0] pix, exp_pix; logic [UW-1:0] u; int lat; logic va;
    logic seen;
    beat_t b;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(rand_beat());
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pix !== '0) begin
      errors++;
      $display("FAIL midreset_clear got v=%b %h want v=0 0", out_valid, out_pix);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_ghost got=1 want=0"); end
    b = rand_beat();
    exp_pix = model(b);
    do_single(b, pix, u, lat, va);
    checks++;
    if (lat != 3 || pix !== exp_pix) begin
      errors++;
      $display("FAIL midreset_next got lat=%0d %h want lat=3 %h", lat, pix, exp_pix);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
    fx = '0; fy = '0; p00 = '0; p10 = '0; p01 = '0; p11 = '0; in_user = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_zero_phase();
    test_half_phase();
    test_edges();
    test_channels();
    test_back_to_back();
    test_stream();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
